// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the EX-stage divider requester: FSM states, divider
// control codes and start-line levels.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        DivCtlIdle    = 2'd0,
        DivCtlBusy    = 2'd1,
        DivCtlRelease = 2'd2,
        DivCtlAbort   = 2'd3
    } div_ctl_state_e;

    localparam logic [4:0] DIV_CONTROL  = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL = 5'b11011;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

endpackage

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU to the iterative divider, stalls F/D/E while it runs, retires
// the {rem,quot} result as a one-cycle HI/LO write, and aborts on flush or hang.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DW         = 32,
    parameter int ABORT_WAIT = 2,
    parameter int TIMEOUT    = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_div_e,
    input  logic [4:0]      alucontrolE,
    input  logic [DW-1:0]   srca_e,
    input  logic [DW-1:0]   srcb_e,
    input  logic            flush_e,
    output logic            div_start_o,
    output logic            div_annul_o,
    output logic [4:0]      div_ctrl_o,
    output logic [DW-1:0]   div_op1_o,
    output logic [DW-1:0]   div_op2_o,
    input  logic [2*DW-1:0] div_result_i,
    input  logic            div_ready_i,
    output logic            div_stall_o,
    output logic            hilo_we_o,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            timeout_o
);

    localparam int CW = $clog2(TIMEOUT + ABORT_WAIT + 1);

    div_ctl_state_e state_q;
    logic [CW-1:0]  cnt_q;
    logic           start_q;
    logic           annul_q;
    logic [4:0]     ctrl_q;
    logic [DW-1:0]  op1_q;
    logic [DW-1:0]  op2_q;
    logic           hilo_we_q;
    logic [DW-1:0]  hi_q;
    logic [DW-1:0]  lo_q;
    logic           timeout_q;
    logic           new_div;

    assign new_div = is_div_e & ~flush_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DivCtlIdle;
            cnt_q     <= '0;
            start_q   <= DivStop;
            annul_q   <= 1'b0;
            ctrl_q    <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            hilo_we_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                DivCtlIdle: begin
                    hilo_we_q <= 1'b0;
                    annul_q   <= 1'b0;
                    timeout_q <= 1'b0;
                    if (new_div) begin
                        op1_q   <= srca_e;
                        op2_q   <= srcb_e;
                        ctrl_q  <= alucontrolE;
                        start_q <= DivStart;
                        cnt_q   <= '0;
                        state_q <= DivCtlBusy;
                    end
                end
                DivCtlBusy: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Flush wins over a simultaneous ready so a killed divide never writes HI/LO.
                    if (flush_e) begin
                        annul_q <= 1'b1;
                        start_q <= DivStop;
                        cnt_q   <= '0;
                        state_q <= DivCtlAbort;
                    end else if (div_ready_i) begin
                        hi_q      <= div_result_i[2*DW-1:DW];
                        lo_q      <= div_result_i[DW-1:0];
                        hilo_we_q <= 1'b1;
                        start_q   <= DivStop;
                        state_q   <= DivCtlRelease;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        annul_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        start_q   <= DivStop;
                        cnt_q     <= '0;
                        state_q   <= DivCtlAbort;
                    end
                end
                DivCtlRelease: begin
                    hilo_we_q <= 1'b0;
                    state_q   <= DivCtlIdle;
                end
                DivCtlAbort: begin
                    annul_q   <= 1'b0;
                    timeout_q <= 1'b0;
                    if (cnt_q == CW'(ABORT_WAIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= DivCtlIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= DivCtlIdle;
            endcase
        end
    end

    // Stall is combinational so EX advances on the same edge the divider reports ready.
    always_comb begin
        div_stall_o = 1'b0;
        case (state_q)
            DivCtlIdle:    div_stall_o = new_div;
            DivCtlBusy:    div_stall_o = ~div_ready_i;
            DivCtlRelease: div_stall_o = new_div;
            DivCtlAbort:   div_stall_o = new_div;
            default:       div_stall_o = 1'b0;
        endcase
        if (rst) div_stall_o = 1'b0;
    end

    assign div_start_o = start_q;
    assign div_annul_o = annul_q;
    assign div_ctrl_o  = ctrl_q;
    assign div_op1_o   = op1_q;
    assign div_op2_o   = op2_q;
    assign hilo_we_o   = hilo_we_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl, paired with a small behavioural model of
// the iterative divider (fixed latency, fast path on zero divisor, stuck mode).
module tb_div_issue_ctrl;
   import div_issue_ctrl_pkg::*;

   localparam int DW  = 32;
   localparam int LAT = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          isDivE;
   logic [4:0]    aluControlE;
   logic [DW-1:0] srcaE;
   logic [DW-1:0] srcbE;
   logic          flushE;
   logic          divStart;
   logic          divAnnul;
   logic [4:0]    divCtrl;
   logic [DW-1:0] divOp1;
   logic [DW-1:0] divOp2;
   logic [2*DW-1:0] divResult;
   logic          divReady;
   logic          divStall;
   logic          hiloWe;
   logic [DW-1:0] hiOut;
   logic [DW-1:0] loOut;
   logic          timeoutOut;

   int checks = 0;
   int errors = 0;

   logic stuck = 1'b0;
   int   modelState;
   int   modelCnt;
   logic [2*DW-1:0] modelRes;

   div_issue_ctrl #(.DW(DW), .ABORT_WAIT(2), .TIMEOUT(40)) dut (
      .clk(clock), .rst(reset), .is_div_e(isDivE), .alucontrolE(aluControlE),
      .srca_e(srcaE), .srcb_e(srcbE), .flush_e(flushE),
      .div_start_o(divStart), .div_annul_o(divAnnul), .div_ctrl_o(divCtrl),
      .div_op1_o(divOp1), .div_op2_o(divOp2), .div_result_i(divResult),
      .div_ready_i(divReady), .div_stall_o(divStall), .hilo_we_o(hiloWe),
      .hi_o(hiOut), .lo_o(loOut), .timeout_o(timeoutOut)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Reference divider arithmetic: {rem,quot}, zero on a zero divisor.
   function automatic logic [2*DW-1:0] divModel(input logic [4:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic signed [DW-1:0] sq;
      logic signed [DW-1:0] sr;
      if (b == '0) return '0;
      if (c == DIV_CONTROL) begin
         sq = $signed(a) / $signed(b);
         sr = $signed(a) % $signed(b);
         return {sr, sq};
      end
      return {a % b, a / b};
   endfunction

   // Divider model: free -> run (LAT cycles, 1 on divide-by-zero) -> end (ready held until start drops).
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         modelState <= 0;
         modelCnt   <= 0;
         modelRes   <= '0;
         divReady   <= 1'b0;
         divResult  <= '0;
      end else if (divAnnul) begin
         modelState <= 0;
         divReady   <= 1'b0;
      end else begin
         case (modelState)
            0: if (divStart) begin
               modelState <= 1;
               modelCnt   <= (divOp2 == '0) ? 1 : LAT;
               modelRes   <= divModel(divCtrl, divOp1, divOp2);
            end
            1: if (!stuck) begin
               if (modelCnt == 1) begin
                  modelState <= 2;
                  divReady   <= 1'b1;
                  divResult  <= modelRes;
               end else begin
                  modelCnt <= modelCnt - 1;
               end
            end
            default: if (!divStart) begin
               modelState <= 0;
               divReady   <= 1'b0;
            end
         endcase
      end
   end

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
      isDivE      = 1'b1;
      aluControlE = c;
      srcaE       = a;
      srcbE       = b;
   endtask

   // Hold the instruction in EX until stall drops; returns at the negedge of the ready cycle.
   task automatic waitNoStall(input int maxCyc, output int stallCyc, output bit timedOut, output int weSeen);
      stallCyc = 0;
      timedOut = 1'b1;
      weSeen   = 0;
      for (int i = 0; i < maxCyc; i++) begin
         @(negedge clock);
         if (hiloWe) weSeen++;
         if (!divStall) begin
            timedOut = 1'b0;
            break;
         end
         stallCyc++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; isDivE = 1'b0; aluControlE = '0; srcaE = '0; srcbE = '0; flushE = 1'b0;
      #1;
      checks++;
      if ({divStart, divAnnul, hiloWe, timeoutOut, divStall} !== 5'b0) begin
         errors++; $display("[TB] FAIL reset_ctl got %b need 00000", {divStart, divAnnul, hiloWe, timeoutOut, divStall});
      end
      checks++;
      if ({divCtrl, divOp1, divOp2, hiOut, loOut} !== '0) begin
         errors++; $display("[TB] FAIL reset_data got op1=%h op2=%h hi=%h lo=%h need all 0", divOp1, divOp2, hiOut, loOut);
      end
      tick(); tick();
      #2 reset = 1'b0;
      tick();
   endtask

   task automatic test_div_signed();
      int sc, we; bit to;
      applyStimulus(DIV_CONTROL, 32'hFFFF_FFF9, 32'h2);
      waitNoStall(100, sc, to, we);
      checks++;
      if (to !== 1'b0) begin errors++; $display("[TB] FAIL div_wait got timed_out=1 need 0"); end
      checks++;
      if (sc != 18) begin errors++; $display("[TB] FAIL div_stall_len got %0d need 18", sc); end
      checks++;
      if ({divStart, divCtrl, divOp1, divOp2} !== {1'b1, DIV_CONTROL, 32'hFFFF_FFF9, 32'h2}) begin
         errors++; $display("[TB] FAIL div_latch got start=%b ctrl=%h op1=%h op2=%h", divStart, divCtrl, divOp1, divOp2);
      end
      tick();
      isDivE = 1'b0; srcaE = 32'hDEAD_BEEF;
      @(negedge clock);
      checks++;
      if ({hiloWe, divStart, divStall, hiOut, loOut} !== {3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
         errors++; $display("[TB] FAIL div_result got we=%b start=%b stall=%b hi=%h lo=%h need 1 0 0 ffffffff fffffffd",
                            hiloWe, divStart, divStall, hiOut, loOut);
      end
      tick();
      @(negedge clock);
      checks++;
      if ({hiloWe, we} !== {1'b0, 32'd0}) begin errors++; $display("[TB] FAIL div_we_pulse got we=%b early=%0d need 0 0", hiloWe, we); end
   endtask

   task automatic test_divu();
      int sc, we; bit to;
      tick();
      applyStimulus(DIVU_CONTROL, 32'hFFFF_FFFF, 32'h10);
      waitNoStall(100, sc, to, we);
      checks++;
      if ({to, divStart} !== 2'b01) begin errors++; $display("[TB] FAIL divu_ready got to=%b start=%b need 0 1", to, divStart); end
      tick();
      isDivE = 1'b0;
      @(negedge clock);
      checks++;
      if ({hiloWe, divStart, hiOut, loOut} !== {2'b10, 32'h0000_000F, 32'h0FFF_FFFF}) begin
         errors++; $display("[TB] FAIL divu_result got we=%b start=%b hi=%h lo=%h need 1 0 0000000f 0fffffff", hiloWe, divStart, hiOut, loOut);
      end
      tick();
      @(negedge clock);
      checks++;
      if ({hiloWe, divStart, divStall} !== 3'b000) begin errors++; $display("[TB] FAIL divu_idle got %b need 000", {hiloWe, divStart, divStall}); end
   endtask

   task automatic test_div_zero();
      int sc, we, weAfter, toAfter; bit to;
      tick();
      applyStimulus(DIV_CONTROL, 32'h0000_1234, 32'h0);
      waitNoStall(20, sc, to, we);
      checks++;
      if (to !== 1'b0 || sc != 3) begin errors++; $display("[TB] FAIL dz_stall_len got %0d timed_out=%b need 3 0", sc, to); end
      tick();
      isDivE = 1'b0;
      @(negedge clock);
      checks++;
      if ({hiloWe, timeoutOut, hiOut, loOut} !== {2'b10, 64'h0}) begin
         errors++; $display("[TB] FAIL dz_result got we=%b to=%b hi=%h lo=%h need 1 0 0 0", hiloWe, timeoutOut, hiOut, loOut);
      end
      weAfter = 0; toAfter = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clock);
         if (hiloWe) weAfter++;
         if (timeoutOut) toAfter++;
      end
      checks++;
      if (weAfter != 0 || toAfter != 0) begin errors++; $display("[TB] FAIL dz_once got extra_we=%0d timeouts=%0d need 0 0", weAfter, toAfter); end
   endtask

   task automatic test_flush();
      int sc, we; bit to;
      tick();
      applyStimulus(DIVU_CONTROL, 32'd50, 32'd3);
      tick();
      repeat (10) tick();
      flushE = 1'b1;
      @(negedge clock);
      checks++;
      if (divStall !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_stall got %b need 1", divStall); end
      tick();
      flushE = 1'b0; isDivE = 1'b0;
      @(negedge clock);
      checks++;
      if ({divAnnul, divStart, hiloWe, divStall, timeoutOut} !== 5'b10000) begin
         errors++; $display("[TB] FAIL flush_abort got %b need 10000", {divAnnul, divStart, hiloWe, divStall, timeoutOut});
      end
      tick();
      applyStimulus(DIVU_CONTROL, 32'd100, 32'd7);
      @(negedge clock);
      checks++;
      if ({divAnnul, divStall, divStart, hiloWe} !== 4'b0100) begin
         errors++; $display("[TB] FAIL flush_refetch got %b need 0100", {divAnnul, divStall, divStart, hiloWe});
      end
      tick();
      waitNoStall(100, sc, to, we);
      tick();
      isDivE = 1'b0;
      @(negedge clock);
      checks++;
      if ({to, we[0], hiloWe, hiOut, loOut} !== {3'b001, 32'd2, 32'd14}) begin
         errors++; $display("[TB] FAIL flush_next got to=%b we=%b hi=%h lo=%h need 0 1 2 14", to, hiloWe, hiOut, loOut);
      end
   endtask

   task automatic test_back_to_back();
      int sc, we; bit to;
      tick();
      applyStimulus(DIVU_CONTROL, 32'd9, 32'd2);
      waitNoStall(100, sc, to, we);
      tick();
      applyStimulus(DIV_CONTROL, 32'hFFFF_FFF7, 32'd2);
      @(negedge clock);
      checks++;
      if ({to, hiloWe, divStall, divStart, hiOut, loOut} !== {4'b0110, 32'd1, 32'd4}) begin
         errors++; $display("[TB] FAIL b2b_release got to=%b we=%b stall=%b start=%b hi=%h lo=%h need 0 1 1 0 1 4",
                            to, hiloWe, divStall, divStart, hiOut, loOut);
      end
      tick();
      @(negedge clock);
      checks++;
      if ({divStall, hiloWe, divStart} !== 3'b100) begin errors++; $display("[TB] FAIL b2b_issue got %b need 100", {divStall, hiloWe, divStart}); end
      tick();
      @(negedge clock);
      checks++;
      if ({divStart, divCtrl, divOp1} !== {1'b1, DIV_CONTROL, 32'hFFFF_FFF7}) begin
         errors++; $display("[TB] FAIL b2b_second got start=%b ctrl=%h op1=%h", divStart, divCtrl, divOp1);
      end
      tick();
      waitNoStall(100, sc, to, we);
      tick();
      isDivE = 1'b0;
      @(negedge clock);
      checks++;
      if ({to, hiloWe, hiOut, loOut} !== {2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFC}) begin
         errors++; $display("[TB] FAIL b2b_result got to=%b we=%b hi=%h lo=%h need 0 1 ffffffff fffffffc", to, hiloWe, hiOut, loOut);
      end
   endtask

   task automatic test_reset_mid_busy();
      tick();
      applyStimulus(DIV_CONTROL, 32'd100, 32'd7);
      repeat (6) tick();
      reset = 1'b1;
      #1;
      checks++;
      if ({divStart, divAnnul, hiloWe, timeoutOut, divStall, divCtrl, divOp1, divOp2, hiOut, loOut} !== '0) begin
         errors++; $display("[TB] FAIL rst_mid got start=%b stall=%b op1=%h hi=%h lo=%h need all 0", divStart, divStall, divOp1, hiOut, loOut);
      end
      isDivE = 1'b0;
      tick();
      #2 reset = 1'b0;
      tick();
      @(negedge clock);
      checks++;
      if ({divStart, divStall, divReady} !== 3'b000) begin errors++; $display("[TB] FAIL rst_after got %b need 000", {divStart, divStall, divReady}); end
   endtask

   task automatic test_timeout();
      int hit, weCnt;
      tick();
      stuck = 1'b1;
      applyStimulus(DIVU_CONTROL, 32'd5, 32'd1);
      hit = -1; weCnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (hiloWe) weCnt++;
         if (timeoutOut) begin hit = i; break; end
         tick();
      end
      checks++;
      if (hit != 41) begin errors++; $display("[TB] FAIL tmo_cycle got %0d need 41", hit); end
      checks++;
      if ({divAnnul, divStart, hiloWe, weCnt[0]} !== 4'b1000) begin
         errors++; $display("[TB] FAIL tmo_abort got annul=%b start=%b we=%b weCnt=%0d need 1 0 0 0", divAnnul, divStart, hiloWe, weCnt);
      end
      tick();
      isDivE = 1'b0;
      @(negedge clock);
      checks++;
      if ({timeoutOut, divAnnul} !== 2'b00) begin errors++; $display("[TB] FAIL tmo_pulse got %b need 00", {timeoutOut, divAnnul}); end
      tick(); tick();
      @(negedge clock);
      checks++;
      if ({divStall, divStart, hiloWe} !== 3'b000) begin errors++; $display("[TB] FAIL tmo_idle got %b need 000", {divStall, divStart, hiloWe}); end
      stuck = 1'b0;
   endtask

   // Scenario sequence; each task leaves the DUT idle for the next.
   initial begin
      test_reset();
      test_div_signed();
      test_divu();
      test_div_zero();
      test_flush();
      test_back_to_back();
      test_reset_mid_busy();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
